triple_select_arbiter: RTL

TRIPLE_SELECT_ARBITER -- requirements
Module: triple_select_arbiter

---
 rtl/triple_select_arbiter_pkg.sv | 40 ++++
 rtl/triple_select_arbiter_mux.sv | 22 ++
 rtl/triple_select_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/triple_select_arbiter_pkg.sv
// Shared definitions for the triple select arbiter: word width, state
// encoding, burst defaults and the arbitration decision helper.
package triple_select_arbiter_pkg;

  // Width of every data word in a triple.
  localparam int WORD_W = 32;

  // Default number of consecutive grants one side may take while the
  // other side is also requesting.
  localparam int BURST_MAX_DEFAULT = 4;

  // Burst counter width; holds values up to 15.
  localparam int BURST_W = 4;

  // Output slot state encoding.
  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_FULL_A = 2'd1;
  localparam logic [1:0] ST_FULL_B = 2'd2;

  // Returns 1 when side A should win the slot.
  // A lone requester always wins. With both requesting, the current owner
  // keeps the slot until its burst allowance is spent, then the other side
  // takes over. With no requester the result is unused.
  function automatic logic pick_a(input logic req_a,
                                  input logic req_b,
                                  input logic owner_a,
                                  input logic burst_spent);
    logic result;
    result = owner_a;
    if (req_a && !req_b) begin
      result = 1'b1;
    end else if (!req_a && req_b) begin
      result = 1'b0;
    end else if (req_a && req_b) begin
      result = burst_spent ? !owner_a : owner_a;
    end
    return result;
  endfunction

endpackage

// File: rtl/triple_select_arbiter_mux.sv
// Three-word 2:1 selector: routes either the A triple or the B triple
// to the output register inputs. Sel = 1 picks A.
module Mux32Bit6To3
  import triple_select_arbiter_pkg::*;
(
  input  logic [WORD_W-1:0] A1,
  input  logic [WORD_W-1:0] A2,
  input  logic [WORD_W-1:0] A3,
  input  logic [WORD_W-1:0] B1,
  input  logic [WORD_W-1:0] B2,
  input  logic [WORD_W-1:0] B3,
  input  logic              Sel,
  output logic [WORD_W-1:0] O1,
  output logic [WORD_W-1:0] O2,
  output logic [WORD_W-1:0] O3
);

  assign O1 = Sel ? A1 : B1;
  assign O2 = Sel ? A2 : B2;
  assign O3 = Sel ? A3 : B3;

endmodule

// File: rtl/triple_select_arbiter.sv
// Two-source triple arbiter with a single registered output slot.
//
// Handshake semantics:
//   Input side : ReqA/ReqB is a request; AckA/AckB is a combinational strobe
//                meaning "the triple on your inputs is captured at this clock
//                edge". A requester keeps Req and data steady until its Ack.
//                Dropping Req before Ack simply withdraws the request.
//   Output side: OutValid/OutReady follow valid/ready rules. A triple is
//                consumed on any edge where both are high. While OutValid is
//                high and OutReady is low, Out1..Out3 and Sel do not change.
//                A consumed slot can be refilled on the same edge, so one
//                triple per cycle flows when the consumer is always ready.
module triple_select_arbiter
  import triple_select_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               ReqA,
  input  logic [WORD_W-1:0]  A1,
  input  logic [WORD_W-1:0]  A2,
  input  logic [WORD_W-1:0]  A3,
  output logic               AckA,
  input  logic               ReqB,
  input  logic [WORD_W-1:0]  B1,
  input  logic [WORD_W-1:0]  B2,
  input  logic [WORD_W-1:0]  B3,
  output logic               AckB,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WORD_W-1:0]  Out1,
  output logic [WORD_W-1:0]  Out2,
  output logic [WORD_W-1:0]  Out3,
  output logic               Sel,
  output logic [CNT_W-1:0]   TransferCount,
  output logic [1:0]         DbgState,
  output logic [BURST_W-1:0] DbgBurstCnt
);

  localparam logic [BURST_W-1:0] BurstMax = BURST_W'(BURST_MAX);

  // Slot state and output register
  logic [1:0]         state_q, state_d;
  logic [WORD_W-1:0]  out1_q, out2_q, out3_q;
  logic               sel_q, sel_d;

  // Fairness bookkeeping: who owns the current burst and how long it is
  logic               owner_a_q, owner_a_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  // Delivered triple counter
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Decision signals
  logic               out_valid;
  logic               consume;
  logic               slot_free;
  logic               any_req;
  logic               grant_a;
  logic               grant;

  // Selected triple headed for the output register
  logic [WORD_W-1:0]  mux_o1, mux_o2, mux_o3;

  assign out_valid = (state_q != ST_EMPTY);
  assign consume   = out_valid & OutReady;
  assign slot_free = (state_q == ST_EMPTY) | consume;
  assign any_req   = ReqA | ReqB;
  assign grant_a   = pick_a(ReqA, ReqB, owner_a_q, burst_q >= BurstMax);

  // Rst gates the grant so no Ack can appear while the block is held in reset.
  assign grant = Rst & slot_free & any_req;
  assign AckA  = grant & grant_a;
  assign AckB  = grant & ~grant_a;

  Mux32Bit6To3 u_mux (
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .B1  (B1),
    .B2  (B2),
    .B3  (B3),
    .Sel (grant_a),
    .O1  (mux_o1),
    .O2  (mux_o2),
    .O3  (mux_o3)
  );

  // Next-state: slot fill/drain, owner and burst tracking, transfer counting.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    owner_a_d = owner_a_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;

    if (consume) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (grant) begin
      state_d = grant_a ? ST_FULL_A : ST_FULL_B;
      sel_d   = grant_a;
      if (grant_a == owner_a_q) begin
        // Saturate so a long solo run cannot overflow the counter.
        if (burst_q < BurstMax) begin
          burst_d = burst_q + 1'b1;
        end
      end else begin
        owner_a_d = grant_a;
        burst_d   = {{(BURST_W-1){1'b0}}, 1'b1};
      end
    end else if (consume) begin
      state_d = ST_EMPTY;
    end
  end

  // Control registers; reset leaves the slot empty with A as burst owner.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_EMPTY;
      sel_q     <= 1'b0;
      owner_a_q <= 1'b1;
      burst_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      owner_a_q <= owner_a_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
    end
  end

  // Output data register; loads only on a grant so data is sampled at Ack.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out1_q <= '0;
      out2_q <= '0;
      out3_q <= '0;
    end else if (grant) begin
      out1_q <= mux_o1;
      out2_q <= mux_o2;
      out3_q <= mux_o3;
    end
  end

  assign OutValid      = out_valid;
  assign Out1          = out1_q;
  assign Out2          = out2_q;
  assign Out3          = out3_q;
  assign Sel           = sel_q;
  assign TransferCount = cnt_q;
  assign DbgState      = state_q;
  assign DbgBurstCnt   = burst_q;

endmodule
